// File: rtl/spr_pkg.sv
// Shared constants and helpers for the sprite renderer/compositor.
package spr_pkg;

  localparam int H_RES     = 640;
  localparam int V_RES     = 480;
  localparam int COLR_BITS = 4;
  localparam int CORDW     = 16;
  localparam int BG_CODE   = 15;

  typedef logic [COLR_BITS-1:0] colr_t;
  typedef logic [CORDW-1:0]     coord_t;

  // Half-open span test done one bit wider than a coordinate so lo+len never wraps.
  function automatic logic in_span(input logic [CORDW:0] v,
                                   input logic [CORDW:0] lo,
                                   input logic [CORDW:0] len);
    return (v >= lo) && (v < lo + len);
  endfunction

endpackage

// File: rtl/sprite_engine.sv
// One scaled sprite channel: row FSM driven by line pulses, column counter driven by sx,
// ROM address generation and the opaque flag aligned with returning ROM data.
module sprite_engine import spr_pkg::*; #(
  parameter int SPR_W = 17,
  parameter int SPR_H = 18,
  parameter int SCALE = 4,
  localparam int ADDRW = $clog2(SPR_W * SPR_H)
) (
  input  logic                 clk_pix,
  input  logic                 rst_n,
  input  logic                 i_frame,
  input  logic                 i_line,
  input  logic [CORDW-1:0]     i_sx,
  input  logic [CORDW-1:0]     i_sy,
  input  logic [CORDW-1:0]     i_x,
  input  logic [CORDW-1:0]     i_y,
  input  logic                 i_en,
  input  logic [COLR_BITS-1:0] i_rom_data,
  output logic [ADDRW-1:0]     o_rom_addr,
  output logic [COLR_BITS-1:0] o_code,
  output logic                 o_opaque
);

  localparam int SPAN_W = SPR_W * SCALE;
  localparam int SPAN_H = SPR_H * SCALE;
  localparam int RW     = (SPR_H > 1) ? $clog2(SPR_H) : 1;
  localparam int CW     = (SPR_W > 1) ? $clog2(SPR_W) : 1;
  localparam int SW     = (SCALE > 1) ? $clog2(SCALE) : 1;

  typedef enum logic [1:0] {ST_IDLE, ST_ACTIVE, ST_DONE} eng_state_t;

  eng_state_t       r_state;
  logic [RW-1:0]    r_row;
  logic [SW-1:0]    r_rsub;
  logic [ADDRW-1:0] r_rowbase;
  logic [CW-1:0]    r_col;
  logic [SW-1:0]    r_csub;
  logic             r_hit_p1;
  logic             r_hit_p2;
  logic [ADDRW-1:0] r_addr_p1;
  logic             w_start;
  logic             w_hit;

  assign w_start = i_en && in_span({1'b0, i_sy}, {1'b0, i_y}, (CORDW+1)'(SPAN_H));
  assign w_hit   = (r_state == ST_ACTIVE) && (i_sx < CORDW'(H_RES)) &&
                   in_span({1'b0, i_sx}, {1'b0, i_x}, (CORDW+1)'(SPAN_W));

  // Row state: a frame pulse restarts the engine, but a coincident line pulse may start it at once
  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_row     <= '0;
      r_rsub    <= '0;
      r_rowbase <= '0;
    end else begin
      if (i_frame) r_state <= ST_IDLE;
      if (i_line) begin
        if (i_frame || r_state == ST_IDLE) begin
          if (w_start) begin
            r_state   <= ST_ACTIVE;
            r_row     <= '0;
            r_rsub    <= '0;
            r_rowbase <= '0;
          end
        end else if (r_state == ST_ACTIVE) begin
          if (r_rsub == SW'(SCALE - 1)) begin
            r_rsub <= '0;
            if (r_row == RW'(SPR_H - 1)) begin
              r_state <= ST_DONE;
            end else begin
              r_row     <= r_row + RW'(1);
              r_rowbase <= r_rowbase + ADDRW'(SPR_W);
            end
          end else begin
            r_rsub <= r_rsub + SW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_csub    <= '0;
      r_hit_p1  <= 1'b0;
      r_addr_p1 <= '0;
      r_hit_p2  <= 1'b0;
    end else begin
      // S1: hit test and address
      r_hit_p1 <= w_hit;
      if (w_hit) begin
        r_addr_p1 <= r_rowbase + ADDRW'(r_col);
        if (r_csub == SW'(SCALE - 1)) begin
          r_csub <= '0;
          r_col  <= r_col + CW'(1);
        end else begin
          r_csub <= r_csub + SW'(1);
        end
      end else begin
        r_addr_p1 <= '0;
        r_col     <= '0;
        r_csub    <= '0;
      end
      // S2: ROM data for the S1 address arrives alongside this flag
      r_hit_p2 <= r_hit_p1;
    end
  end

  assign o_rom_addr = r_addr_p1;
  assign o_code     = r_hit_p2 ? i_rom_data : '0;
  assign o_opaque   = (o_code != '0);

endmodule

// File: rtl/sprite_compositor.sv
// Multi-sprite compositor: frame-shadowed positions, per-sprite engines, priority merge,
// 3-stage sync delay and per-frame collision flags.
module sprite_compositor import spr_pkg::*; #(
  parameter int NUM_SPR = 4,
  parameter int SPR_W   = 17,
  parameter int SPR_H   = 18,
  parameter int SCALE   = 4,
  localparam int ADDRW  = $clog2(SPR_W * SPR_H)
) (
  input  logic                         clk_pix,
  input  logic                         rst_n,
  input  logic [CORDW-1:0]             sx,
  input  logic [CORDW-1:0]             sy,
  input  logic                         de,
  input  logic                         hsync,
  input  logic                         vsync,
  input  logic                         frame,
  input  logic                         line,
  input  logic [NUM_SPR*CORDW-1:0]     spr_x,
  input  logic [NUM_SPR*CORDW-1:0]     spr_y,
  input  logic [NUM_SPR-1:0]           spr_en,
  output logic [NUM_SPR*ADDRW-1:0]     rom_addr,
  input  logic [NUM_SPR*COLR_BITS-1:0] rom_data,
  output logic [COLR_BITS-1:0]         pix_code,
  output logic                         out_de,
  output logic                         out_hs,
  output logic                         out_vs,
  output logic [NUM_SPR-1:0]           collide,
  output logic                         collide_vld
);

  logic [NUM_SPR*CORDW-1:0]     r_x;
  logic [NUM_SPR*CORDW-1:0]     r_y;
  logic [NUM_SPR-1:0]           r_en;
  logic [NUM_SPR*CORDW-1:0]     w_x;
  logic [NUM_SPR*CORDW-1:0]     w_y;
  logic [NUM_SPR-1:0]           w_en;
  logic                         r_vld_p1, r_vld_p2;
  logic                         r_hs_p1, r_hs_p2;
  logic                         r_vs_p1, r_vs_p2;
  logic                         r_fr_p1, r_fr_p2;
  logic [NUM_SPR*COLR_BITS-1:0] w_code;
  logic [NUM_SPR-1:0]           w_opq;
  logic [NUM_SPR-1:0]           w_ovl;
  logic [NUM_SPR-1:0]           r_acc;
  logic [COLR_BITS-1:0]         w_pix;
  logic                         w_multi;

  // Values being captured are used on the frame pulse itself so a sprite at y=0 still starts
  assign w_x  = frame ? spr_x  : r_x;
  assign w_y  = frame ? spr_y  : r_y;
  assign w_en = frame ? spr_en : r_en;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_x  <= '0;
      r_y  <= '0;
      r_en <= '0;
    end else if (frame) begin
      r_x  <= spr_x;
      r_y  <= spr_y;
      r_en <= spr_en;
    end
  end

  for (genvar g = 0; g < NUM_SPR; g++) begin : g_eng
    sprite_engine #(
      .SPR_W (SPR_W),
      .SPR_H (SPR_H),
      .SCALE (SCALE)
    ) u_eng (
      .clk_pix    (clk_pix),
      .rst_n      (rst_n),
      .i_frame    (frame),
      .i_line     (line),
      .i_sx       (sx),
      .i_sy       (sy),
      .i_x        (w_x[g*CORDW +: CORDW]),
      .i_y        (w_y[g*CORDW +: CORDW]),
      .i_en       (w_en[g]),
      .i_rom_data (rom_data[g*COLR_BITS +: COLR_BITS]),
      .o_rom_addr (rom_addr[g*ADDRW +: ADDRW]),
      .o_code     (w_code[g*COLR_BITS +: COLR_BITS]),
      .o_opaque   (w_opq[g])
    );
  end

  always_comb begin
    w_pix = COLR_BITS'(BG_CODE);
    for (int i = NUM_SPR - 1; i >= 0; i--) begin
      if (w_opq[i]) w_pix = w_code[i*COLR_BITS +: COLR_BITS];
    end
  end

  assign w_multi = (w_opq & (w_opq - NUM_SPR'(1))) != '0;
  assign w_ovl   = (r_vld_p2 && w_multi) ? w_opq : '0;

  always_ff @(posedge clk_pix or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1    <= 1'b0;
      r_hs_p1     <= 1'b0;
      r_vs_p1     <= 1'b0;
      r_fr_p1     <= 1'b0;
      r_vld_p2    <= 1'b0;
      r_hs_p2     <= 1'b0;
      r_vs_p2     <= 1'b0;
      r_fr_p2     <= 1'b0;
      pix_code    <= '0;
      out_de      <= 1'b0;
      out_hs      <= 1'b0;
      out_vs      <= 1'b0;
      collide     <= '0;
      collide_vld <= 1'b0;
      r_acc       <= '0;
    end else begin
      // S1
      r_vld_p1 <= de;
      r_hs_p1  <= hsync;
      r_vs_p1  <= vsync;
      r_fr_p1  <= frame;
      // S2
      r_vld_p2 <= r_vld_p1;
      r_hs_p2  <= r_hs_p1;
      r_vs_p2  <= r_vs_p1;
      r_fr_p2  <= r_fr_p1;
      // S3: merge, aligned syncs, collision accumulate/publish
      pix_code    <= r_vld_p2 ? w_pix : '0;
      out_de      <= r_vld_p2;
      out_hs      <= r_hs_p2;
      out_vs      <= r_vs_p2;
      collide_vld <= r_fr_p2;
      if (r_fr_p2) begin
        collide <= r_acc;
        r_acc   <= w_ovl;
      end else begin
        r_acc <= r_acc | w_ovl;
      end
    end
  end

endmodule

// File: tb/tb_sprite_compositor.sv
// Randomized bench for sprite_compositor against a geometric per-pixel reference model.
module tb_sprite_compositor;

  localparam int NSPR  = 4;
  localparam int SPR_W = 17;
  localparam int SPR_H = 18;
  localparam int SCALE = 4;
  localparam int ADDRW = 9;
  localparam int BG    = 15;
  localparam int NWORD = SPR_W * SPR_H;

  logic clk = 1'b0;
  always #20 clk = ~clk;

  logic              rst_n;
  logic [15:0]       sx, sy;
  logic              de, hs, vs, fr, ln;
  logic [NSPR*16-1:0] spr_x, spr_y;
  logic [NSPR-1:0]   spr_en;
  logic [NSPR*ADDRW-1:0] rom_addr;
  logic [NSPR*4-1:0] rom_data;
  logic [3:0]        pix_code;
  logic              out_de, out_hs, out_vs;
  logic [NSPR-1:0]   collide;
  logic              collide_vld;

  logic [3:0] rom_mem [NSPR][NWORD];

  sprite_compositor #(
    .NUM_SPR (NSPR),
    .SPR_W   (SPR_W),
    .SPR_H   (SPR_H),
    .SCALE   (SCALE)
  ) dut (
    .clk_pix     (clk),
    .rst_n       (rst_n),
    .sx          (sx),
    .sy          (sy),
    .de          (de),
    .hsync       (hs),
    .vsync       (vs),
    .frame       (fr),
    .line        (ln),
    .spr_x       (spr_x),
    .spr_y       (spr_y),
    .spr_en      (spr_en),
    .rom_addr    (rom_addr),
    .rom_data    (rom_data),
    .pix_code    (pix_code),
    .out_de      (out_de),
    .out_hs      (out_hs),
    .out_vs      (out_vs),
    .collide     (collide),
    .collide_vld (collide_vld)
  );

  function automatic logic [3:0] rom_rd(input int i, input logic [ADDRW-1:0] a);
    return (int'(a) < NWORD) ? rom_mem[i][a] : 4'h0;
  endfunction

  always @(posedge clk) begin
    for (int i = 0; i < NSPR; i++) rom_data[i*4 +: 4] <= rom_rd(i, rom_addr[i*ADDRW +: ADDRW]);
  end

  typedef struct packed {
    logic [3:0] pix;
    logic [2:0] sync;
    logic [4:0] coll;
  } exp_t;

  exp_t       q[$];
  int         m_x[NSPR];
  int         m_y[NSPR];
  bit         m_en[NSPR];
  logic [3:0] m_acc;
  logic [3:0] m_coll;
  int         n_chk  = 0;
  int         n_pass = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] expv);
    n_chk++;
    if (got === expv) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, expv, $time);
  endtask

  task automatic model_reset();
    exp_t z;
    z = '0;
    q.delete();
    for (int i = 0; i < NSPR; i++) begin
      m_x[i] = 0; m_y[i] = 0; m_en[i] = 0;
    end
    m_acc  = '0;
    m_coll = '0;
    q.push_back(z);
    q.push_back(z);
  endtask

  // One pixel clock: apply inputs, predict the output 3 cycles later, check the one due now.
  task automatic drive(input int x, input int y, input logic d, input logic f, input logic l);
    exp_t       e;
    logic [3:0] opq;
    logic [3:0] pix;
    logic [3:0] code;
    @(negedge clk);
    sx = 16'(x); sy = 16'(y); de = d; fr = f; ln = l;
    hs = 1'($urandom_range(0, 1));
    vs = 1'($urandom_range(0, 1));
    if (f) begin
      for (int i = 0; i < NSPR; i++) begin
        m_x[i]  = int'(spr_x[i*16 +: 16]);
        m_y[i]  = int'(spr_y[i*16 +: 16]);
        m_en[i] = spr_en[i];
      end
    end
    opq = '0;
    pix = 4'(BG);
    for (int i = NSPR - 1; i >= 0; i--) begin
      if (m_en[i] && x < 640 && x >= m_x[i] && x < m_x[i] + SPR_W*SCALE &&
          y >= m_y[i] && y < m_y[i] + SPR_H*SCALE) begin
        code = rom_mem[i][((y - m_y[i]) / SCALE) * SPR_W + (x - m_x[i]) / SCALE];
        if (code != 4'h0) begin
          opq[i] = 1'b1;
          pix    = code;
        end
      end
    end
    e.pix  = d ? pix : 4'h0;
    e.sync = {d, hs, vs};
    if (f) begin
      m_coll = m_acc;
      m_acc  = '0;
    end
    if (d && $countones(opq) >= 2) m_acc = m_acc | opq;
    e.coll = {f, m_coll};
    q.push_back(e);
    @(posedge clk);
    #1;
    if (q.size() == 3) begin
      e = q.pop_front();
      chk("pix_code", 64'(pix_code), 64'(e.pix));
      chk("de_hs_vs", 64'({out_de, out_hs, out_vs}), 64'(e.sync));
      chk("collide", 64'({collide_vld, collide}), 64'(e.coll));
    end
  endtask

  function automatic logic vis(input int x, input int y);
    return (x < 640) && (y < 480) && ($urandom_range(0, 15) != 0);
  endfunction

  task automatic frame_start();
    drive(799, 0, 1'b0, 1'b1, 1'b1);
  endtask

  task automatic scan_line(input int y, input int xlo, input int xhi);
    drive(799, y, 1'b0, 1'b0, 1'b1);
    for (int x = xlo; x <= xhi; x++) drive(x, y, vis(x, y), 1'b0, 1'b0);
  endtask

  task automatic scan_lines(input int ylo, input int yhi, input int xlo, input int xhi);
    for (int y = ylo; y <= yhi; y++) scan_line(y, xlo, xhi);
  endtask

  task automatic set_spr(input int i, input int x, input int y);
    spr_x[i*16 +: 16] = 16'(x);
    spr_y[i*16 +: 16] = 16'(y);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_pix"},  64'(pix_code), 64'(0));
    chk({tag, "_sync"}, 64'({out_de, out_hs, out_vs}), 64'(0));
    chk({tag, "_coll"}, 64'({collide_vld, collide}), 64'(0));
    chk({tag, "_addr"}, 64'(rom_addr), 64'(0));
  endtask

  initial begin
    int ylo, xlo, v;
    rst_n = 1'b0;
    sx = '0; sy = '0; de = 1'b0; hs = 1'b0; vs = 1'b0; fr = 1'b0; ln = 1'b0;
    spr_x = '0; spr_y = '0; spr_en = '0;
    for (int a = 0; a < NWORD; a++) begin
      rom_mem[0][a] = 4'((a % 15) + 1);
      for (int i = 1; i < NSPR; i++) begin
        v = int'($urandom_range(0, 15));
        if ($urandom_range(0, 3) == 0) v = 0;
        rom_mem[i][a] = 4'(v);
      end
    end

    repeat (3) @(posedge clk);
    #1;
    check_zero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();

    // Single sprite at (100,300)
    set_spr(0, 100, 300);
    spr_en = 4'b0001;
    frame_start();
    scan_lines(298, 373, 96, 172);

    // Two sprites stacked at (200,200)
    set_spr(1, 200, 200);
    set_spr(0, 200, 200);
    spr_en = 4'b0011;
    frame_start();
    scan_lines(198, 273, 196, 272);

    // Sprite 1 moved clear of sprite 0
    set_spr(1, 400, 200);
    frame_start();
    scan_lines(198, 210, 196, 470);

    // Mid-frame position change is deferred to the next frame
    set_spr(0, 100, 240);
    spr_en = 4'b0001;
    frame_start();
    scan_lines(238, 249, 96, 172);
    set_spr(0, 140, 240);
    scan_lines(250, 262, 96, 172);
    frame_start();
    scan_lines(238, 250, 96, 215);

    // Clipping at the right and bottom edges, and no wrap to the top-left
    set_spr(0, 630, 470);
    frame_start();
    scan_lines(466, 484, 600, 660);
    frame_start();
    scan_lines(0, 8, 0, 16);

    // Asynchronous reset while sprite 0 is active on line 310
    set_spr(0, 100, 300);
    frame_start();
    scan_lines(298, 309, 96, 172);
    drive(799, 310, 1'b0, 1'b0, 1'b1);
    for (int x = 96; x <= 130; x++) drive(x, 310, vis(x, 310), 1'b0, 1'b0);
    #5 rst_n = 1'b0;
    #1 check_zero("async_rst");
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
    model_reset();
    scan_lines(311, 320, 96, 172);
    frame_start();
    scan_lines(298, 305, 96, 172);

    // Randomized placements, last round with everything disabled
    for (int r = 0; r < 4; r++) begin
      ylo = int'($urandom_range(20, 380));
      xlo = int'($urandom_range(0, 560));
      for (int i = 0; i < NSPR; i++)
        set_spr(i, xlo + int'($urandom_range(0, 40)), ylo + int'($urandom_range(0, 12)));
      spr_en = (r == 3) ? 4'b0000 : 4'($urandom_range(1, 15));
      frame_start();
      scan_lines(ylo, ylo + 40, xlo, xlo + 90);
    end
    frame_start();
    scan_lines(10, 12, 0, 20);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
